// File: rtl/alu_cmd_pkg.sv
// Shared types and select-field constants for the ALU command sequencer.
package alu_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Shift field, sel[5:4]
    localparam logic [1:0] SH_RIGHT = 2'b00;
    localparam logic [1:0] SH_LEFT  = 2'b11;

    // Mode bit, sel[3]
    localparam logic MODE_LOGIC = 1'b1;
    localparam logic MODE_ARITH = 1'b0;

    // Function field, sel[2:0]
    localparam logic [2:0] FN_0 = 3'd0;
    localparam logic [2:0] FN_1 = 3'd1;
    localparam logic [2:0] FN_2 = 3'd2;
    localparam logic [2:0] FN_3 = 3'd3;
    localparam logic [2:0] FN_4 = 3'd4;
    localparam logic [2:0] FN_5 = 3'd5;
    localparam logic [2:0] FN_6 = 3'd6;
    localparam logic [2:0] FN_7 = 3'd7;

    // The ALU defines only right and left shifts; the other two codes are undefined.
    function automatic logic is_bad_shift(input logic [1:0] sh);
        return (sh != SH_RIGHT) && (sh != SH_LEFT);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module alu_cmd_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    // Pointer update; push and pop are each gated by their own occupancy flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (i_pop && !o_empty) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset since empty masks them
    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, drives them one at a time into a combinational ALU and
// returns each sampled result over a valid/ready response channel.
module alu_cmd_sequencer
    import alu_cmd_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [SIZE-1:0]  cmd_a,
    input  logic [SIZE-1:0]  cmd_b,
    input  logic             cmd_cin,
    input  logic [5:0]       cmd_sel,
    output logic [SIZE-1:0]  alu_a,
    output logic [SIZE-1:0]  alu_b,
    output logic             alu_cin,
    output logic [5:0]       alu_sel,
    input  logic [SIZE-1:0]  alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [SIZE-1:0]  rsp_y,
    output logic             rsp_err,
    output logic [CNT_W-1:0] ops_done
);

    localparam int FW = 2 * SIZE + 7;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [FW-1:0]   w_head;
    logic [SIZE-1:0] w_head_a;
    logic [SIZE-1:0] w_head_b;
    logic            w_head_cin;
    logic [5:0]      w_head_sel;
    logic            w_bad_shift;

    state_t          r_state;
    logic [SIZE-1:0] r_alu_a;
    logic [SIZE-1:0] r_alu_b;
    logic            r_alu_cin;
    logic [5:0]      r_alu_sel;
    logic            r_rsp_valid;
    logic [SIZE-1:0] r_rsp_y;
    logic            r_rsp_err;
    logic [CNT_W-1:0] r_ops_done;

    // No bypass: readiness depends only on occupancy
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (r_state == IDLE) && !w_empty;

    assign {w_head_a, w_head_b, w_head_cin, w_head_sel} = w_head;
    assign w_bad_shift = is_bad_shift(r_alu_sel[5:4]);

    alu_cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_wdata ({cmd_a, cmd_b, cmd_cin, cmd_sel}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Issue FSM: pop and drive, give the ALU one settle cycle, then hold the result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_cin   <= 1'b0;
            r_alu_sel   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_err   <= 1'b0;
            r_ops_done  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_alu_a   <= w_head_a;
                        r_alu_b   <= w_head_b;
                        r_alu_cin <= w_head_cin;
                        r_alu_sel <= w_head_sel;
                        r_state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    // Undefined shift codes give a zeroed result flagged as an error
                    r_rsp_y     <= w_bad_shift ? '0 : alu_y;
                    r_rsp_err   <= w_bad_shift;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ops_done  <= r_ops_done + CNT_W'(1);
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_cin   = r_alu_cin;
    assign alu_sel   = r_alu_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign rsp_err   = r_rsp_err;
    assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: behavioural ALU plus a response queue model.
module tb_alu_cmd_sequencer;

    localparam int SIZE  = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [SIZE-1:0]  cmd_a;
    logic [SIZE-1:0]  cmd_b;
    logic             cmd_cin;
    logic [5:0]       cmd_sel;
    logic [SIZE-1:0]  alu_a;
    logic [SIZE-1:0]  alu_b;
    logic             alu_cin;
    logic [5:0]       alu_sel;
    logic [SIZE-1:0]  alu_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [SIZE-1:0]  rsp_y;
    logic             rsp_err;
    logic [CNT_W-1:0] ops_done;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned exp_ops  = 0;
    int unsigned rsp_seen = 0;
    logic [8:0]  exp_q [$];

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_cin   (cmd_cin),
        .cmd_sel   (cmd_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err),
        .ops_done  (ops_done)
    );

    // Behavioural ALU; undefined shift codes produce a garbage pattern
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic [5:0] sel);
        logic [7:0] r;
        if (sel[3]) begin
            case (sel[2:0])
                3'd0: r = a & b;
                3'd1: r = a | b;
                3'd2: r = a ^ b;
                3'd3: r = ~a;
                3'd4: r = ~(a & b);
                3'd5: r = ~(a | b);
                3'd6: r = ~(a ^ b);
                default: r = b;
            endcase
        end else begin
            case (sel[2:0])
                3'd0: r = a;
                3'd1: r = a + 8'd1;
                3'd2: r = a + b + {7'd0, cin};
                3'd3: r = a - b;
                3'd4: r = a + {7'd0, cin};
                3'd5: r = a - 8'd1;
                3'd6: r = a + b;
                default: r = b - a;
            endcase
        end
        case (sel[5:4])
            2'b00:   return r >> 1;
            2'b11:   return r << 1;
            default: return 8'hA5;
        endcase
    endfunction

    function automatic logic [8:0] expect_rsp(input logic [7:0] a, input logic [7:0] b,
                                              input logic cin, input logic [5:0] sel);
        if (sel[5:4] == 2'b01 || sel[5:4] == 2'b10) return {1'b1, 8'h00};
        return {1'b0, alu_fn(a, b, cin, sel)};
    endfunction

    always_comb alu_y = alu_fn(alu_a, alu_b, alu_cin, alu_sel);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, update the model after it
    task automatic cycle();
        logic       rst_s;
        logic       push_hs;
        logic       rsp_hs;
        logic [8:0] got;
        logic [8:0] nxt;
        logic [8:0] want;
        rst_s   = rst;
        push_hs = cmd_valid && cmd_ready;
        rsp_hs  = rsp_valid && rsp_ready;
        got     = {rsp_err, rsp_y};
        nxt     = expect_rsp(cmd_a, cmd_b, cmd_cin, cmd_sel);
        @(posedge clk);
        #1;
        if (rst_s) begin
            exp_q.delete();
            exp_ops = 0;
        end else begin
            if (rsp_hs) begin
                rsp_seen++;
                exp_ops++;
                check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    check("rsp_data", 32'(got), 32'(want));
                end
            end
            if (push_hs) exp_q.push_back(nxt);
        end
        check("ops_done", 32'(ops_done), 32'(exp_ops[CNT_W-1:0]));
    endtask

    task automatic push_one(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic [5:0] sel);
        int k;
        cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_sel = sel;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            cycle();
            k++;
        end
        check("push_wait", 32'(k < 50), 32'd1);
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int k;
        k = 0;
        while (!rsp_valid && k < 50) begin
            cycle();
            k++;
        end
        check("rsp_wait", 32'(rsp_valid), 32'd1);
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [5:0] sel,
                           input logic [7:0] exp_y, input logic exp_err);
        int unsigned ops_before;
        rsp_ready = 1'b0;
        push_one(a, b, cin, sel);
        wait_rsp();
        check({tag, "_y"}, 32'(rsp_y), 32'(exp_y));
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        ops_before = 32'(ops_done);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        check({tag, "_valid_clr"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ops_inc"}, 32'(ops_done), ops_before + 1);
    endtask

    logic [22:0] bp_cmd [6];
    logic [7:0]  rnd_a;
    logic [7:0]  rnd_b;
    logic [7:0]  rst_a1;
    int          sent;
    bit          done;
    bit          will_push;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; cmd_sel = '0;
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_alu", 32'({alu_a, alu_b, alu_cin, alu_sel}), 32'd0);
        check("rst_rsp", 32'({rsp_err, rsp_y}), 32'd0);

        // Latency: push at E0, pop at E1, response after E2
        cmd_a = 8'h0F; cmd_b = 8'h01; cmd_cin = 1'b1; cmd_sel = 6'b000010;
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        check("lat_e0_valid", 32'(rsp_valid), 32'd0);
        check("lat_e0_alu_a", 32'(alu_a), 32'h00);
        cycle();
        check("lat_e1_valid", 32'(rsp_valid), 32'd0);
        check("lat_e1_alu", 32'({alu_a, alu_b, alu_cin, alu_sel}), 32'({8'h0F, 8'h01, 1'b1, 6'b000010}));
        cycle();
        check("lat_e2_valid", 32'(rsp_valid), 32'd1);
        check("lat_e2_y", 32'(rsp_y), 32'h08);
        check("lat_e2_err", 32'(rsp_err), 32'd0);
        cycle();
        check("lat_hold_valid", 32'(rsp_valid), 32'd1);
        check("lat_hold_y", 32'(rsp_y), 32'h08);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        check("lat_done_valid", 32'(rsp_valid), 32'd0);
        check("lat_done_alu_hold", 32'(alu_a), 32'h0F);

        run_cmd("logic_shl", 8'hF0, 8'h3C, 1'b0, 6'b111000, 8'h60, 1'b0);
        run_cmd("wrap", 8'hFF, 8'h01, 1'b0, 6'b110110, 8'h00, 1'b0);
        rnd_a = 8'($urandom); rnd_b = 8'($urandom);
        run_cmd("bad_sh01", rnd_a, rnd_b, 1'b1, 6'b010000, 8'h00, 1'b1);
        run_cmd("bad_sh10", rnd_b, rnd_a, 1'b0, 6'b101011, 8'h00, 1'b1);

        // Backpressure: one in RESP, four queued, sixth stalls
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bp_cmd[i] = {8'($urandom), 8'($urandom), 1'($urandom),
                         ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00, 4'($urandom)};
        end
        for (int i = 0; i < 5; i++) begin
            push_one(bp_cmd[i][22:15], bp_cmd[i][14:7], bp_cmd[i][6], bp_cmd[i][5:0]);
        end
        {cmd_a, cmd_b, cmd_cin, cmd_sel} = bp_cmd[5];
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_first", 32'({rsp_err, rsp_y}),
                  32'(expect_rsp(bp_cmd[0][22:15], bp_cmd[0][14:7], bp_cmd[0][6],
                                 bp_cmd[0][5:0])));
            cycle();
        end
        rsp_seen = 0;
        rsp_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            will_push = cmd_valid && cmd_ready;
            cycle();
            if (will_push) cmd_valid = 1'b0;
            done = !cmd_valid && !rsp_valid && (exp_q.size() == 0);
        end
        check("bp_rsp_count", rsp_seen, 32'd6);
        check("bp_drained", 32'(done), 32'd1);

        // Random traffic
        sent = 0;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (!cmd_valid && sent < 60 && $urandom_range(0, 9) < 7) begin
                cmd_a = 8'($urandom); cmd_b = 8'($urandom);
                cmd_cin = 1'($urandom); cmd_sel = 6'($urandom);
                cmd_valid = 1'b1;
            end
            rsp_ready = 1'($urandom);
            will_push = cmd_valid && cmd_ready;
            cycle();
            if (will_push) begin
                sent++;
                cmd_valid = 1'b0;
            end
            done = (sent == 60) && !rsp_valid && (exp_q.size() == 0);
        end
        check("rand_all_sent", 32'(sent), 32'd60);
        check("rand_drained", 32'(done), 32'd1);

        // Reset while in DRIVE with three queued
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_a = 8'($urandom) | 8'h01; cmd_b = 8'($urandom);
            cmd_cin = 1'($urandom); cmd_sel = 6'b000001;
            if (i == 1) rst_a1 = cmd_a;
            cmd_valid = 1'b1;
            check("rstq_cmd_ready", 32'(cmd_ready), 32'd1);
            cycle();
        end
        cmd_valid = 1'b0;
        check("rstq_in_drive", 32'(alu_a), 32'(rst_a1));
        check("rstq_no_rsp_yet", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rstq_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstq_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rstq_ops", 32'(ops_done), 32'd0);
        check("rstq_alu", 32'({alu_a, alu_b, alu_cin, alu_sel}), 32'd0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("rstq_no_stale", 32'(rsp_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
